// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the memory-stage LSU (master) and the data memory (slave).
// One request/acknowledge transaction per load or store.
interface mem_stage_lsu_if;
  logic        MemReq;
  logic        MemWe;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic [3:0]  MemWStrb;
  logic [31:0] MemRData;
  logic        MemAck;

  modport master (
    output MemReq, MemWe, MemAddr, MemWData, MemWStrb,
    input  MemRData, MemAck
  );

  modport slave (
    input  MemReq, MemWe, MemAddr, MemWData, MemWStrb,
    output MemRData, MemAck
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit plus MEM/WB pipeline register for the 5-stage RV32I core.
// Issues one bus transaction per aligned load/store and stalls upstream until it is acknowledged.
module mem_stage_lsu (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            ALUResultM,
  input  logic [31:0]            WriteDataM,
  input  logic [31:0]            PCPlus4M,
  input  logic [4:0]             RdM,
  input  logic                   RegWriteM,
  input  logic                   MemWriteM,
  input  logic [1:0]             ResultSrcM,
  input  logic [2:0]             Funct3M,
  mem_stage_lsu_if.master        bus,
  output logic                   StallM,
  output logic [31:0]            ReadDataW,
  output logic [31:0]            ALUResultW,
  output logic [31:0]            PCPlus4W,
  output logic [4:0]             RdW,
  output logic                   RegWriteW,
  output logic [1:0]             ResultSrcW,
  output logic                   MisalignW
);

  typedef enum logic {
    S_IDLE,
    S_ACCESS
  } state_e;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } bus_t;

  typedef struct packed {
    logic [31:0] read_data;
    logic [31:0] alu_result;
    logic [31:0] pc_plus4;
    logic [4:0]  rd;
    logic        reg_write;
    logic [1:0]  result_src;
    logic        misalign;
  } wb_t;

  state_e state_q, state_d;
  bus_t   bus_q, bus_d;
  wb_t    wb_q, wb_d;
  logic   stall;

  logic        is_load;
  logic        is_store;
  logic        mem_op;
  logic        misaligned;
  logic [1:0]  addr_lo;
  logic [3:0]  store_strb;
  logic [31:0] store_data;
  logic [31:0] rdata_shifted;
  logic [31:0] load_data;

  // Access decode: a store wins when both store and load controls are set.
  assign addr_lo  = ALUResultM[1:0];
  assign is_store = MemWriteM;
  assign is_load  = (ResultSrcM == 2'b01) && !MemWriteM;
  assign mem_op   = MemWriteM || (ResultSrcM == 2'b01);

  always_comb begin
    misaligned = 1'b0;
    case (Funct3M[1:0])
      2'b01:   misaligned = addr_lo[0];
      2'b10:   misaligned = (addr_lo != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  always_comb begin
    store_strb = 4'b1111;
    store_data = WriteDataM;
    case (Funct3M[1:0])
      2'b00: begin
        store_strb = 4'b0001 << addr_lo;
        store_data = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        store_strb = addr_lo[1] ? 4'b1100 : 4'b0011;
        store_data = {2{WriteDataM[15:0]}};
      end
      default: begin
        store_strb = 4'b1111;
        store_data = WriteDataM;
      end
    endcase
  end

  // Move the addressed byte/halfword down to bit 0, then extend per Funct3M[2].
  assign rdata_shifted = bus.MemRData >> {addr_lo, 3'b000};

  always_comb begin
    load_data = bus.MemRData;
    case (Funct3M[1:0])
      2'b00:   load_data = Funct3M[2] ? {24'd0, rdata_shifted[7:0]}
                                      : {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      2'b01:   load_data = Funct3M[2] ? {16'd0, rdata_shifted[15:0]}
                                      : {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      default: load_data = bus.MemRData;
    endcase
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    bus_d   = bus_q;
    wb_d    = '0;
    stall   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mem_op && !misaligned) begin
          stall      = 1'b1;
          state_d    = S_ACCESS;
          bus_d.req  = 1'b1;
          bus_d.we   = is_store;
          bus_d.addr = {ALUResultM[31:2], 2'b00};
          bus_d.wdata = is_store ? store_data : 32'd0;
          bus_d.strb  = is_store ? store_strb : 4'b0000;
        end else begin
          wb_d.alu_result = ALUResultM;
          wb_d.pc_plus4   = PCPlus4M;
          wb_d.rd         = RdM;
          wb_d.result_src = ResultSrcM;
          wb_d.misalign   = mem_op;
          wb_d.reg_write  = RegWriteM && !mem_op;
        end
      end

      S_ACCESS: begin
        if (bus.MemAck) begin
          state_d         = S_IDLE;
          bus_d           = '0;
          wb_d.read_data  = is_load ? load_data : 32'd0;
          wb_d.alu_result = ALUResultM;
          wb_d.pc_plus4   = PCPlus4M;
          wb_d.rd         = RdM;
          wb_d.result_src = ResultSrcM;
          wb_d.reg_write  = RegWriteM;
        end else begin
          stall = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        bus_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      bus_q   <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      bus_q   <= bus_d;
      wb_q    <= wb_d;
    end
  end

  // Stall is gated by reset so every output reads 0 while reset is held.
  assign StallM = stall && !rst;

  assign bus.MemReq   = bus_q.req;
  assign bus.MemWe    = bus_q.we;
  assign bus.MemAddr  = bus_q.addr;
  assign bus.MemWData = bus_q.wdata;
  assign bus.MemWStrb = bus_q.strb;

  assign ReadDataW  = wb_q.read_data;
  assign ALUResultW = wb_q.alu_result;
  assign PCPlus4W   = wb_q.pc_plus4;
  assign RdW        = wb_q.rd;
  assign RegWriteW  = wb_q.reg_write;
  assign ResultSrcW = wb_q.result_src;
  assign MisalignW  = wb_q.misalign;

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Memory-stage load/store unit and MEM/WB pipeline register for the 5-stage RV32I core. It consumes the EX/MEM register outputs and issues one request/acknowledge transaction per load or store to the data memory bus. It stalls the upstream pipeline until the memory acknowledges the access, then formats load data and registers it with the writeback fields into the W stage.

## Interface
- No parameters. Data width is fixed at 32 and the register index at 5.
- clk  in  1  core clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- ALUResultM  in  32  effective address for loads and stores; the result value otherwise.
- WriteDataM  in  32  store data (rs2).
- PCPlus4M  in  32  PC+4 of the M instruction.
- RdM  in  5  destination register.
- RegWriteM, MemWriteM  in  1  control bits.
- ResultSrcM  in  2  00 = ALU, 01 = load, 10 = PC+4.
- Funct3M  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu.
- MemReq, MemWe  out  1  bus request and write enable.
- MemAddr  out  32  word-aligned address, {ALUResultM[31:2], 2'b00}.
- MemWData  out  32  lane-positioned store data.
- MemWStrb  out  4  byte strobes; 0000 on reads.
- MemRData  in  32  read word, valid in the MemAck cycle.
- MemAck  in  1  one-cycle access-complete pulse.
- StallM  out  1  holds the F/D/E/M registers.
- ReadDataW, ALUResultW, PCPlus4W  out  32  registered writeback data.
- RdW  out  5, RegWriteW  out  1, ResultSrcW  out  2: registered writeback fields.
- MisalignW  out  1  the W instruction was a misaligned access.

## Operation
- MemOp = MemWriteM | (ResultSrcM == 01). When both are set, the access is a store.
- Misaligned: word access with addr[1:0] != 0, or halfword access with addr[0] != 0.
- A misaligned access issues no bus request and stalls for 0 cycles. The W register loads MisalignW = 1 and RegWriteW = 0.
- FSM states are IDLE and ACCESS.
  - IDLE with an aligned MemOp: StallM = 1 (combinational) and the state moves to ACCESS. The bus outputs are registered, so MemReq rises at the next edge.
  - IDLE without MemOp: StallM = 0 and the W register loads the M fields.
  - ACCESS: MemReq = 1. MemWe, MemAddr, MemWData and MemWStrb stay constant until MemAck.
  - ACCESS with MemAck = 0: StallM = 1.
  - ACCESS with MemAck = 1: StallM = 0, the W register loads, and the state moves to IDLE. MemReq drops at that edge.
- While StallM = 1, the W register loads a bubble: RegWriteW = 0, MisalignW = 0, all other W outputs 0.
- Store lanes:
  - sb: strobe = 0001 << addr[1:0], data = {4{WriteDataM[7:0]}}.
  - sh: strobe = 0011 or 1100 selected by addr[1], data = {2{WriteDataM[15:0]}}.
  - sw: strobe = 1111.
- Load formatting: select the byte or halfword using addr[1:0]. lb and lh sign-extend; lbu and lhu zero-extend. The formatted value is captured into ReadDataW on the MemAck cycle.
- MemAck while in IDLE is ignored.

## Timing
- Reset: every output is 0 and the state is IDLE. This includes MemReq, MemWe, MemWStrb, StallM, all W fields and MisalignW.
- A reset asserted during ACCESS drops MemReq at the same edge. The transaction is abandoned, and a late MemAck after reset is ignored.
- Non-memory instructions and misaligned accesses reach W one cycle after entering M.
- An aligned access with a 0-wait bus (MemAck in the first ACCESS cycle) spends 2 cycles in M. With N wait cycles it spends 2 + N cycles in M.
- Back-to-back memory ops: after the ack cycle the next op enters IDLE. MemReq is 0 for at least 1 cycle between transactions.
- StallM must not depend on MemRData.

## Test plan
- sw: addr 0x100, data 0xDEADBEEF, ack 0-wait. Required: MemReq high 1 cycle, MemAddr 0x100, MemWStrb 1111, StallM high 1 cycle, then RegWriteW = 0.
- sb: addr 0x103, data 0x000000A5. Required: MemWStrb 1000 and MemWData 0xA5A5A5A5.
- lb versus lbu: addr 0x201, MemRData 0x1234F600, 3 wait cycles. Required: StallM high 4 cycles; ReadDataW = 0xFFFFFFF6 for lb and 0x000000F6 for lbu; RdW correct; RegWriteW = 1.
- lw at addr 0x102. Required: no MemReq, StallM = 0, MisalignW = 1, RegWriteW = 0 next cycle.
- rst during ACCESS, followed by a MemAck 1 cycle later. Required: MemReq = 0 after the reset edge, all outputs 0, and the state stays IDLE.
- add followed by lw followed by add, 0-wait bus. Required: W sequence add, bubble, lw, add, with the bubble inserted during the stall.
